// File: rtl/nodf_mon_pkg.sv
// Shared types and default sizes for the non-dataflow HLS block status tracker.
package nodf_mon_pkg;

  localparam int NODF_CNT_W = 32;
  localparam int NODF_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACTIVE   = 2'd1,
    STALL    = 2'd2,
    FINISHED = 2'd3
  } mon_state_e;

endpackage

// File: rtl/nodf_ts_fifo.sv
// Start-timestamp FIFO: synchronous, W bits by DEPTH entries (DEPTH a power of two).
// A push is accepted when full only if a pop happens in the same cycle.
module nodf_ts_fifo
  import nodf_mon_pkg::*;
#(
  parameter int W     = NODF_CNT_W,
  parameter int DEPTH = NODF_DEPTH
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 din,
  output logic [W-1:0]                 dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == OCC_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop) begin
        count <= count + OCC_W'(1);
      end else if (do_pop && !do_push) begin
        count <= count - OCC_W'(1);
      end
    end
  end

endmodule

// File: rtl/nodf_module_status_tracker.sv
// Status tracker for one ap_ctrl_hs HLS block: counts, latency, state and sticky errors.
// Min/max latency tracking is built only when NODF_MON_LATENCY_STATS_EN is defined.
module nodf_module_status_tracker
  import nodf_mon_pkg::*;
#(
  parameter int CNT_W = NODF_CNT_W,
  parameter int DEPTH = NODF_DEPTH
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         ap_start,
  input  logic                         ap_ready,
  input  logic                         ap_done,
  input  logic                         ap_continue,
  input  logic                         finish,
  output logic [1:0]                   state,
  output logic [CNT_W-1:0]             start_cnt,
  output logic [CNT_W-1:0]             done_cnt,
  output logic [$clog2(DEPTH+1)-1:0]   outstanding,
  output logic [CNT_W-1:0]             last_latency,
  output logic                         lat_valid,
  output logic [CNT_W-1:0]             min_latency,
  output logic [CNT_W-1:0]             max_latency,
  output logic                         err_overflow,
  output logic                         err_unmatched,
  output logic                         finished
);

  localparam int OCC_W = $clog2(DEPTH+1);

  mon_state_e        state_q;
  mon_state_e        state_d;
  logic [CNT_W-1:0]  cyc_q;
  logic              frozen;
  logic              start_acc;
  logic              done_acc;
  logic              bypass;
  logic              push;
  logic              pop;
  logic              overflow_ev;
  logic              unmatched_ev;
  logic              lat_ev;
  logic [CNT_W-1:0]  lat_val;
  logic [CNT_W-1:0]  fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [OCC_W-1:0]  fifo_count;
  logic [OCC_W-1:0]  next_occ;

  assign frozen = (state_q == FINISHED);

  // ap_start/ap_ready and ap_done/ap_continue are valid/ready pairs: a transfer
  // happens on a cycle where both are high; neither side waits on the other.
  assign start_acc = ap_start && ap_ready && !frozen;
  assign done_acc  = ap_done && ap_continue && !frozen;

  // A done against an empty FIFO consumes the same-cycle start directly.
  assign bypass       = done_acc && start_acc && fifo_empty;
  assign pop          = done_acc && !fifo_empty;
  assign push         = start_acc && !bypass && (!fifo_full || pop);
  assign overflow_ev  = start_acc && !bypass && fifo_full && !pop;
  assign unmatched_ev = done_acc && fifo_empty && !start_acc;
  assign lat_ev       = pop || bypass;
  assign lat_val      = bypass ? '0 : (cyc_q - fifo_head);

  nodf_ts_fifo #(
    .W     (CNT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (cyc_q),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    next_occ = fifo_count;
    if (push && !pop) begin
      next_occ = fifo_count + OCC_W'(1);
    end else if (pop && !push) begin
      next_occ = fifo_count - OCC_W'(1);
    end
  end

  always_comb begin
    state_d = IDLE;
    if (finish || frozen) begin
      state_d = FINISHED;
    end else if (ap_done && !ap_continue) begin
      state_d = STALL;
    end else if (ap_start || (next_occ != '0)) begin
      state_d = ACTIVE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      cyc_q         <= '0;
      start_cnt     <= '0;
      done_cnt      <= '0;
      last_latency  <= '0;
      lat_valid     <= 1'b0;
      err_overflow  <= 1'b0;
      err_unmatched <= 1'b0;
    end else begin
      state_q   <= state_d;
      lat_valid <= lat_ev;
      if (!frozen) begin
        cyc_q <= cyc_q + CNT_W'(1);
        if (start_acc)    start_cnt     <= start_cnt + CNT_W'(1);
        if (done_acc)     done_cnt      <= done_cnt + CNT_W'(1);
        if (lat_ev)       last_latency  <= lat_val;
        if (overflow_ev)  err_overflow  <= 1'b1;
        if (unmatched_ev) err_unmatched <= 1'b1;
      end
    end
  end

`ifdef NODF_MON_LATENCY_STATS_EN
  // Reset values make the first recorded latency load both extremes.
  always_ff @(posedge clock) begin
    if (reset) begin
      min_latency <= '1;
      max_latency <= '0;
    end else if (lat_ev) begin
      if (lat_val < min_latency) min_latency <= lat_val;
      if (lat_val > max_latency) max_latency <= lat_val;
    end
  end
`else
  assign min_latency = '0;
  assign max_latency = '0;
`endif

  assign state       = state_q;
  assign outstanding = fifo_count;
  assign finished    = frozen;

endmodule

// File: tb/tb_nodf_module_status_tracker.sv
// Directed vector bench for nodf_module_status_tracker (CNT_W 32, DEPTH 4).
// Honours NODF_MON_LATENCY_STATS_EN when choosing min/max expectations.
module tb_nodf_module_status_tracker;
  import nodf_mon_pkg::*;

  localparam int CNT_W = 32;
  localparam int DEPTH = 4;
  localparam logic [31:0] ALL1 = 32'hFFFF_FFFF;

  logic              clock;
  logic              reset;
  logic              ap_start, ap_ready, ap_done, ap_continue, finish;
  logic [1:0]        state;
  logic [CNT_W-1:0]  start_cnt, done_cnt, last_latency, min_latency, max_latency;
  logic [2:0]        outstanding;
  logic              lat_valid, err_overflow, err_unmatched, finished;

  typedef struct {
    logic        rst, st, rd, dn, ct, fin;
    logic [1:0]  e_state;
    logic [31:0] e_scnt, e_dcnt;
    logic [2:0]  e_outs;
    logic        e_lv;
    logic [31:0] e_lat;
    logic        e_ovf, e_unm, e_fin;
    logic [31:0] e_mn, e_mx;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  int          n_vec;
  int          n_miss;

  nodf_module_status_tracker #(.CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .clock         (clock),
    .reset         (reset),
    .ap_start      (ap_start),
    .ap_ready      (ap_ready),
    .ap_done       (ap_done),
    .ap_continue   (ap_continue),
    .finish        (finish),
    .state         (state),
    .start_cnt     (start_cnt),
    .done_cnt      (done_cnt),
    .outstanding   (outstanding),
    .last_latency  (last_latency),
    .lat_valid     (lat_valid),
    .min_latency   (min_latency),
    .max_latency   (max_latency),
    .err_overflow  (err_overflow),
    .err_unmatched (err_unmatched),
    .finished      (finished)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic add(input logic rst, st, rd, dn, ct, fin,
                     input logic [1:0] s, input logic [31:0] sc, dc,
                     input logic [2:0] o, input logic lv, input logic [31:0] lat,
                     input logic ovf, unm, ff, input logic [31:0] mn, mx);
    vec_t v;
    v.rst = rst; v.st = st; v.rd = rd; v.dn = dn; v.ct = ct; v.fin = fin;
    v.e_state = s; v.e_scnt = sc; v.e_dcnt = dc; v.e_outs = o; v.e_lv = lv;
    v.e_lat = lat; v.e_ovf = ovf; v.e_unm = unm; v.e_fin = ff;
    v.e_mn = mn; v.e_mx = mx;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, st, rd, dn, ct, fin);
    reset = rst; ap_start = st; ap_ready = rd; ap_done = dn;
    ap_continue = ct; finish = fin;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL vec %0d %s: got %0d expected %0d", idx, name, act, exp);
    end
  endtask

  task automatic check_vec(input int idx, input vec_t v);
    logic [31:0] mn, mx;
`ifdef NODF_MON_LATENCY_STATS_EN
    mn = v.e_mn;
    mx = v.e_mx;
`else
    mn = '0;
    mx = '0;
`endif
    n_vec++;
    chk("state", idx, 32'(state), 32'(v.e_state));
    chk("start_cnt", idx, start_cnt, v.e_scnt);
    chk("done_cnt", idx, done_cnt, v.e_dcnt);
    chk("outstanding", idx, 32'(outstanding), 32'(v.e_outs));
    chk("lat_valid", idx, 32'(lat_valid), 32'(v.e_lv));
    chk("last_latency", idx, last_latency, v.e_lat);
    chk("err_overflow", idx, 32'(err_overflow), 32'(v.e_ovf));
    chk("err_unmatched", idx, 32'(err_unmatched), 32'(v.e_unm));
    chk("finished", idx, 32'(finished), 32'(v.e_fin));
    chk("min_latency", idx, min_latency, mn);
    chk("max_latency", idx, max_latency, mx);
  endtask

  task automatic build_table();
    // single transaction, latency 7
    add(1,0,0,0,1,0, IDLE,   0,0,0,0,0, 0,0,0, ALL1,0);
    add(0,1,1,0,1,0, ACTIVE, 1,0,1,0,0, 0,0,0, ALL1,0);
    for (int i = 0; i < 6; i++) add(0,0,0,0,1,0, ACTIVE, 1,0,1,0,0, 0,0,0, ALL1,0);
    add(0,0,0,1,1,0, IDLE,   1,1,0,1,7, 0,0,0, 7,7);
    add(0,0,0,0,1,0, IDLE,   1,1,0,0,7, 0,0,0, 7,7);
    // pipelined: starts at 1,2,3; dones at 8,9,16
    add(1,0,0,0,1,0, IDLE,   0,0,0,0,0, 0,0,0, ALL1,0);
    add(0,1,1,0,1,0, ACTIVE, 1,0,1,0,0, 0,0,0, ALL1,0);
    add(0,1,1,0,1,0, ACTIVE, 2,0,2,0,0, 0,0,0, ALL1,0);
    add(0,1,1,0,1,0, ACTIVE, 3,0,3,0,0, 0,0,0, ALL1,0);
    for (int i = 0; i < 4; i++) add(0,0,0,0,1,0, ACTIVE, 3,0,3,0,0, 0,0,0, ALL1,0);
    add(0,0,0,1,1,0, ACTIVE, 3,1,2,1,7, 0,0,0, 7,7);
    add(0,0,0,1,1,0, ACTIVE, 3,2,1,1,7, 0,0,0, 7,7);
    for (int i = 0; i < 6; i++) add(0,0,0,0,1,0, ACTIVE, 3,2,1,0,7, 0,0,0, 7,7);
    add(0,0,0,1,1,0, IDLE,   3,3,0,1,13, 0,0,0, 7,13);
    // stall: done held 3 cycles without continue
    add(1,0,0,0,1,0, IDLE,   0,0,0,0,0, 0,0,0, ALL1,0);
    add(0,1,1,0,1,0, ACTIVE, 1,0,1,0,0, 0,0,0, ALL1,0);
    for (int i = 0; i < 3; i++) add(0,0,0,1,0,0, STALL, 1,0,1,0,0, 0,0,0, ALL1,0);
    add(0,0,0,1,1,0, IDLE,   1,1,0,1,4, 0,0,0, 4,4);
    add(0,0,0,0,1,0, IDLE,   1,1,0,0,4, 0,0,0, 4,4);
    // overflow, then push+pop while full
    add(1,0,0,0,1,0, IDLE,   0,0,0,0,0, 0,0,0, ALL1,0);
    add(0,1,1,0,1,0, ACTIVE, 1,0,1,0,0, 0,0,0, ALL1,0);
    add(0,1,1,0,1,0, ACTIVE, 2,0,2,0,0, 0,0,0, ALL1,0);
    add(0,1,1,0,1,0, ACTIVE, 3,0,3,0,0, 0,0,0, ALL1,0);
    add(0,1,1,0,1,0, ACTIVE, 4,0,4,0,0, 0,0,0, ALL1,0);
    add(0,1,1,0,1,0, ACTIVE, 5,0,4,0,0, 1,0,0, ALL1,0);
    add(0,1,1,1,1,0, ACTIVE, 6,1,4,1,5, 1,0,0, 5,5);
    // start without ready, then empty-FIFO bypass
    add(1,0,0,0,1,0, IDLE,   0,0,0,0,0, 0,0,0, ALL1,0);
    add(0,1,0,0,1,0, ACTIVE, 0,0,0,0,0, 0,0,0, ALL1,0);
    add(0,1,1,1,1,0, ACTIVE, 1,1,0,1,0, 0,0,0, 0,0);
    add(0,0,0,0,1,0, IDLE,   1,1,0,0,0, 0,0,0, 0,0);
    // unmatched done, finish with same-cycle start, frozen, reset
    add(1,0,0,0,1,0, IDLE,     0,0,0,0,0, 0,0,0, ALL1,0);
    add(0,0,0,1,1,0, IDLE,     0,1,0,0,0, 0,1,0, ALL1,0);
    add(0,1,1,0,1,1, FINISHED, 1,1,1,0,0, 0,1,1, ALL1,0);
    add(0,1,1,0,1,0, FINISHED, 1,1,1,0,0, 0,1,1, ALL1,0);
    add(0,1,1,1,1,0, FINISHED, 1,1,1,0,0, 0,1,1, ALL1,0);
    add(1,0,0,0,1,0, IDLE,     0,0,0,0,0, 0,0,0, ALL1,0);
  endtask

  initial begin
    n_vec = 0;
    n_miss = 0;
    reset = 1'b1; ap_start = 1'b0; ap_ready = 1'b0; ap_done = 1'b0;
    ap_continue = 1'b1; finish = 1'b0;
    build_table();

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].st, vecs[i].rd, vecs[i].dn, vecs[i].ct, vecs[i].fin);
      check_vec(i, vecs[i]);
    end

    // reset mid-flight drops FIFO contents: the next done is unmatched
    drive(1,0,0,0,1,0);
    drive(0,1,1,0,1,0);
    drive(0,1,1,0,1,0);
    drive(1,1,1,0,1,0);
    n_vec++;
    chk("mid_reset_outstanding", 1000, 32'(outstanding), 0);
    n_vec++;
    chk("mid_reset_start_cnt", 1001, start_cnt, 0);
    drive(0,0,0,1,1,0);
    n_vec++;
    chk("mid_reset_unmatched", 1002, 32'(err_unmatched), 1);
    n_vec++;
    chk("mid_reset_lat_valid", 1003, 32'(lat_valid), 0);

    // back-to-back transactions scored through an expected-latency queue
    drive(1,0,0,0,1,0);
    exp_q.push_back(32'd4);
    exp_q.push_back(32'd4);
    drive(0,1,1,0,1,0);
    drive(0,1,1,0,1,0);
    drive(0,0,0,0,1,0);
    drive(0,0,0,0,1,0);
    drive(0,0,0,1,1,0);
    for (int k = 0; k < 6 && exp_q.size() > 0; k++) begin
      if (lat_valid) begin
        n_vec++;
        chk("queue_latency", 2000 + k, last_latency, exp_q.pop_front());
      end
      drive(0,0,0,(k == 0) ? 1'b1 : 1'b0,1,0);
    end
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
